// File: rtl/vector_pkg.sv
// Shared definitions for the 57-bit packed signed vector format (x|y|z, Q11.8).
// Latency: n/a (package). Backpressure: n/a.
// Used by the vector multiply/divide blocks and their benches.
package vector_pkg;

    localparam int COMP_W = 19;
    localparam int FRAC_W = 8;
    localparam int VEC_W  = 3 * COMP_W;

    localparam int X_LSB = 38;
    localparam int Y_LSB = 19;
    localparam int Z_LSB = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_X = 3'd1,
        MUL_Y = 3'd2,
        MUL_Z = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/signed_fixed_mul_sat.sv
// Signed fixed-point multiply, floor-rescale by FRAC_W, saturate to COMP_W bits.
// Latency: combinational. Backpressure: none (pure function of a_i/b_i).
// ovf_o flags any result that had to be clamped.
module signed_fixed_mul_sat #(
    parameter int COMP_W = 19,
    parameter int FRAC_W = 8
) (
    input  logic [COMP_W-1:0] a_i,
    input  logic [COMP_W-1:0] b_i,
    output logic [COMP_W-1:0] res_o,
    output logic              ovf_o
);

    localparam int PW = 2 * COMP_W;

    logic [PW-1:0]        prod;
    logic signed [PW-1:0] shifted;
    logic [PW-COMP_W:0]   head;

    always_comb begin
        // Sign-extending both operands makes the low PW bits of an unsigned
        // multiply equal to the signed product.
        prod    = {{COMP_W{a_i[COMP_W-1]}}, a_i} * {{COMP_W{b_i[COMP_W-1]}}, b_i};
        shifted = $signed(prod) >>> FRAC_W;
        head    = shifted[PW-1:COMP_W-1];
        ovf_o   = !((&head) || !(|head));
        res_o   = shifted[COMP_W-1:0];
        if (ovf_o) begin
            res_o = shifted[PW-1] ? {1'b1, {(COMP_W-1){1'b0}}}
                                  : {1'b0, {(COMP_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/signed_vector_multiplication.sv
// Component-wise saturating signed vector multiply, one shared multiplier over x, y, z.
// Latency: accept edge T, out_valid high after edge T+3; no overlap between operations.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module signed_vector_multiplication #(
    parameter int COMP_W = 19,
    parameter int FRAC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*COMP_W-1:0]   in_vector_1,
    input  logic [3*COMP_W-1:0]   in_vector_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*COMP_W-1:0]   out_vector,
    output logic [2:0]            out_overflow
);

    import vector_pkg::*;

    localparam int VW = 3 * COMP_W;
    localparam int XO = 2 * COMP_W;
    localparam int YO = COMP_W;
    localparam int ZO = 0;

    state_e          state_q, state_d;
    logic [VW-1:0]   op1_q, op1_d;
    logic [VW-1:0]   op2_q, op2_d;
    logic [VW-1:0]   res_q, res_d;
    logic [2:0]      ovf_q, ovf_d;

    logic [COMP_W-1:0] mul_a, mul_b, mul_r;
    logic              mul_ovf;

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_vector   = res_q;
    assign out_overflow = ovf_q;

    always_comb begin
        mul_a = op1_q[ZO +: COMP_W];
        mul_b = op2_q[ZO +: COMP_W];
        case (state_q)
            MUL_X: begin
                mul_a = op1_q[XO +: COMP_W];
                mul_b = op2_q[XO +: COMP_W];
            end
            MUL_Y: begin
                mul_a = op1_q[YO +: COMP_W];
                mul_b = op2_q[YO +: COMP_W];
            end
            default: ;
        endcase
    end

    signed_fixed_mul_sat #(
        .COMP_W (COMP_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .res_o (mul_r),
        .ovf_o (mul_ovf)
    );

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op1_d   = in_vector_1;
                    op2_d   = in_vector_2;
                    ovf_d   = 3'b000;
                    state_d = MUL_X;
                end
            end
            MUL_X: begin
                res_d[XO +: COMP_W] = mul_r;
                ovf_d[2]            = mul_ovf;
                state_d             = MUL_Y;
            end
            MUL_Y: begin
                res_d[YO +: COMP_W] = mul_r;
                ovf_d[1]            = mul_ovf;
                state_d             = MUL_Z;
            end
            MUL_Z: begin
                res_d[ZO +: COMP_W] = mul_r;
                ovf_d[0]            = mul_ovf;
                state_d             = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_signed_vector_multiplication.sv
// Directed and random-stream bench for signed_vector_multiplication.
module tb_signed_vector_multiplication;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] in_vector_1;
    logic [56:0] in_vector_2;
    logic        out_valid;
    logic        out_ready;
    logic [56:0] out_vector;
    logic [2:0]  out_overflow;

    int n_vec = 0;
    int n_bad = 0;
    int n_hs  = 0;
    int n_ops = 0;

    signed_vector_multiplication #(
        .COMP_W (19),
        .FRAC_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vector_1  (in_vector_1),
        .in_vector_2  (in_vector_2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vector   (out_vector),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_hs++;
    end

    always @(negedge clk) begin
        if (rst_n) check("ready_valid_exclusive", 64'(in_ready & out_valid), 64'd0);
    end

    function automatic logic [56:0] pk(input logic [18:0] x, input logic [18:0] y, input logic [18:0] z);
        return {x, y, z};
    endfunction

    // Golden component: exact integer product, floor divide by 256, clamp.
    function automatic logic [19:0] ref_mul(input logic [18:0] a, input logic [18:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p >>> 8;
        if (q > 262143)       return {1'b1, 19'h3FFFF};
        else if (q < -262144) return {1'b1, 19'h40000};
        else                  return {1'b0, q[18:0]};
    endfunction

    function automatic logic [18:0] rnd_comp();
        int v;
        if ($urandom_range(0, 1) == 1) return 19'($urandom);
        v = int'($urandom_range(0, 4095)) - 2048;
        return 19'(v);
    endfunction

    // Called at posedge+1 with the DUT in IDLE.
    task automatic run_op(input logic [56:0] a, input logic [56:0] b, input bit rnd,
                          output logic [56:0] r, output logic [2:0] o, output int lat);
        bit done;
        int k;
        r    = '0;
        o    = '0;
        lat  = -1;
        done = 1'b0;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_vector_1 = a;
        in_vector_2 = b;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_vector_1 = ~a;
        in_vector_2 = ~b;
        k = 0;
        while (!done && k < 40) begin
            if (out_valid && lat < 0) lat = k;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                r    = out_vector;
                o    = out_overflow;
                done = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b0;
        check("handshake_seen", 64'(done), 64'd1);
        if (done) begin
            n_ops++;
            check("no_duplicate", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [56:0] r, a, b, e;
        logic [2:0]  o, eo;
        logic [19:0] cx, cy, cz;
        int          lat;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_vector_1 = '0;
        in_vector_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),     64'd1);
        check("rst_out_valid", 64'(out_valid),    64'd0);
        check("rst_vector",    64'(out_vector),   64'd0);
        check("rst_overflow",  64'(out_overflow), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 2.0*3.0 = 6.0 in x, 1.0*1.0 in y
        run_op(pk(19'd512, 19'd256, 19'd0), pk(19'd768, 19'd256, 19'd0), 1'b0, r, o, lat);
        check("basic_vec", 64'(r), 64'(pk(19'd1536, 19'd256, 19'd0)));
        check("basic_ovf", 64'(o), 64'd0);
        check("basic_lat", 64'(lat), 64'd3);

        // -1.5*2.0 = -3.0 in y; -1*128 >> 8 floors to -1 in z
        run_op(pk(19'd0, 19'h7FE80, 19'h7FFFF), pk(19'd0, 19'd512, 19'd128), 1'b0, r, o, lat);
        check("signed_vec", 64'(r), 64'(pk(19'd0, 19'h7FD00, 19'h7FFFF)));
        check("signed_ovf", 64'(o), 64'd0);

        run_op(pk(19'd256000, 19'd256, 19'h41800), pk(19'd512, 19'd256, 19'd512), 1'b0, r, o, lat);
        check("sat_vec", 64'(r), 64'(pk(19'h3FFFF, 19'd256, 19'h40000)));
        check("sat_ovf", 64'(o), 64'b101);

        // Back-pressure: hold DONE, wiggle inputs, result must not move.
        in_vector_1 = pk(19'd512, 19'd256, 19'd0);
        in_vector_2 = pk(19'd768, 19'd256, 19'd0);
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_vector_1 = {$urandom, $urandom};
            in_vector_2 = {$urandom, $urandom};
            in_valid    = 1'b1;
            @(posedge clk); #1;
            check("bp_hold_vec",   64'(out_vector), 64'(pk(19'd1536, 19'd256, 19'd0)));
            check("bp_in_ready",   64'(in_ready),   64'd0);
            check("bp_valid_hold", 64'(out_valid),  64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_ops++;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);

        // Reset while in MUL_Y: x and its flag are already written.
        in_vector_1 = pk(19'd256000, 19'd256, 19'h41800);
        in_vector_2 = pk(19'd512, 19'd256, 19'd512);
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_ovf", 64'(out_overflow), 64'b100);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(in_ready),     64'd1);
        check("midrst_out_valid", 64'(out_valid),    64'd0);
        check("midrst_vector",    64'(out_vector),   64'd0);
        check("midrst_overflow",  64'(out_overflow), 64'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(pk(19'd0, 19'h7FE80, 19'h7FFFF), pk(19'd0, 19'd512, 19'd128), 1'b0, r, o, lat);
        check("post_rst_vec", 64'(r), 64'(pk(19'd0, 19'h7FD00, 19'h7FFFF)));
        check("post_rst_ovf", 64'(o), 64'd0);

        for (int i = 0; i < 101; i++) begin
            a  = pk(rnd_comp(), rnd_comp(), rnd_comp());
            b  = pk(rnd_comp(), rnd_comp(), rnd_comp());
            cx = ref_mul(a[56:38], b[56:38]);
            cy = ref_mul(a[37:19], b[37:19]);
            cz = ref_mul(a[18:0],  b[18:0]);
            e  = {cx[18:0], cy[18:0], cz[18:0]};
            eo = {cx[19], cy[19], cz[19]};
            run_op(a, b, 1'b1, r, o, lat);
            check("rand_vec", 64'(r), 64'(e));
            check("rand_ovf", 64'(o), 64'(eo));
        end

        repeat (2) @(posedge clk);
        #1;
        check("handshake_count", 64'(n_hs), 64'(n_ops));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
